// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to Wishbone B4 pipelined master bridge, one outstanding transaction.
// Optional bus timeout enabled by defining URV_DM_WB_TIMEOUT_EN.
module urv_dm_wb_bridge #(
    parameter int g_timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0] state;
    logic       bus_done;
    logic       timeout;
    logic       complete;
    logic       fail;

`ifdef URV_DM_WB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(g_timeout_cycles - 1);

    logic [7:0] tmo_cnt;

    // Held at zero between cycles so every new cycle starts counting from 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            tmo_cnt <= 8'd0;
        else if (!wb_cyc_o)
            tmo_cnt <= 8'd0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout = wb_cyc_o && (tmo_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // A response only counts in REQ once the strobe has actually been accepted.
    assign bus_done = (wb_ack_i || wb_err_i) &&
                      (((state == ST_REQ) && !wb_stall_i) || (state == ST_WAIT));
    assign complete = bus_done || timeout;
    assign fail     = bus_done ? wb_err_i : 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            wb_adr_o        <= 32'd0;
            wb_dat_o        <= 32'd0;
            wb_sel_o        <= 4'd0;
            wb_we_o         <= 1'b0;
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            dm_data_l_o     <= 32'd0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dm_store_i || dm_load_i) begin
                        wb_adr_o <= dm_addr_i;
                        wb_dat_o <= dm_data_s_i;
                        wb_sel_o <= dm_data_select_i;
                        wb_we_o  <= dm_store_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (complete) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= ST_IDLE;
                        if (wb_we_o) begin
                            dm_store_done_o <= 1'b1;
                        end else begin
                            dm_load_done_o <= 1'b1;
                            dm_data_l_o    <= fail ? 32'd0 : wb_dat_i;
                        end
                        if (fail)
                            err_o <= 1'b1;
                    end else if ((state == ST_REQ) && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
